// File: rtl/gobang_board_hist_if.sv
// rtl/gobang_board_hist_if.sv - request/response bundle of the gobang board store
// Purpose: groups the board requests, display read and status outputs.
// Ports (master drives requests, slave drives responses):
//   clr, write, write_i, write_j, write_color, retract, display_i  -> slave
//   display_black/white, write_ack/rej, retract_ack/nak,
//   last_valid/i/j/color, hist_cnt, round_cnt_unit/tens/hund    -> master
interface gobang_board_hist_if #(
  parameter int BOARD_N = 15,
  parameter int IDX_W   = 5,
  parameter int HIST_AW = 4
);
  logic               clr;
  logic               write;
  logic [IDX_W-1:0]   write_i;
  logic [IDX_W-1:0]   write_j;
  logic               write_color;
  logic               retract;
  logic [IDX_W-1:0]   display_i;
  logic [BOARD_N-1:0] display_black;
  logic [BOARD_N-1:0] display_white;
  logic               write_ack;
  logic               write_rej;
  logic               retract_ack;
  logic               retract_nak;
  logic               last_valid;
  logic [IDX_W-1:0]   last_i;
  logic [IDX_W-1:0]   last_j;
  logic               last_color;
  logic [HIST_AW:0]   hist_cnt;
  logic [3:0]         round_cnt_unit;
  logic [3:0]         round_cnt_tens;
  logic [3:0]         round_cnt_hund;

  modport master (
    output clr, write, write_i, write_j, write_color, retract, display_i,
    input  display_black, display_white, write_ack, write_rej,
           retract_ack, retract_nak, last_valid, last_i, last_j, last_color,
           hist_cnt, round_cnt_unit, round_cnt_tens, round_cnt_hund
  );

  modport slave (
    input  clr, write, write_i, write_j, write_color, retract, display_i,
    output display_black, display_white, write_ack, write_rej,
           retract_ack, retract_nak, last_valid, last_i, last_j, last_color,
           hist_cnt, round_cnt_unit, round_cnt_tens, round_cnt_hund
  );
endinterface

// File: rtl/gobang_board_hist.sv
// rtl/gobang_board_hist.sv - gobang board store with retractable move history
// Purpose: BOARD_N x BOARD_N board as black/white bit-planes with validated
//   writes, a HIST_DEPTH-entry ring of retractable moves, registered row
//   reads for the renderer and a saturating BCD stone count.
// Ports:
//   clk   - system clock, rising edge
//   rst_p - asynchronous active-high reset
//   bus   - gobang_board_hist_if.slave (requests in, pulses/status/rows out)
module gobang_board_hist #(
  parameter int BOARD_N    = 15,
  parameter int IDX_W      = 5,
  parameter int HIST_DEPTH = 16,
  parameter int HIST_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_p,
  gobang_board_hist_if.slave    bus
);

  // Row/column index width actually needed to address the board arrays.
  // In-range indices never use the bits above RW, so slicing is lossless
  // once the range check has passed.
  localparam int          RW        = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam logic [31:0] BOARD_N_U = BOARD_N;
  localparam logic [HIST_AW:0] HIST_FULL = (HIST_AW + 1)'(HIST_DEPTH);

  typedef logic [BOARD_N-1:0] row_t;

  row_t               black_q [BOARD_N];
  row_t               black_d [BOARD_N];
  row_t               white_q [BOARD_N];
  row_t               white_d [BOARD_N];

  logic [IDX_W-1:0]   hist_i_q [HIST_DEPTH];
  logic [IDX_W-1:0]   hist_i_d [HIST_DEPTH];
  logic [IDX_W-1:0]   hist_j_q [HIST_DEPTH];
  logic [IDX_W-1:0]   hist_j_d [HIST_DEPTH];
  logic               hist_c_q [HIST_DEPTH];
  logic               hist_c_d [HIST_DEPTH];

  logic [HIST_AW-1:0] ptr_q, ptr_d;
  logic [HIST_AW:0]   cnt_q, cnt_d;
  logic [11:0]        bcd_q, bcd_d;      // {hund, tens, unit}

  logic               write_ack_q,   write_ack_d;
  logic               write_rej_q,   write_rej_d;
  logic               retract_ack_q, retract_ack_d;
  logic               retract_nak_q, retract_nak_d;
  row_t               disp_black_q,  disp_black_d;
  row_t               disp_white_q,  disp_white_d;

  logic [HIST_AW-1:0] ptr_prev;
  logic               wr_in_range;
  logic               wr_occupied;
  logic               disp_in_range;
  logic [RW-1:0]      wr_r, wr_c, rt_r, rt_c, disp_r;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h000) begin
      if (v[3:0] != 4'd0) begin
        r[3:0] = v[3:0] - 4'd1;
      end else begin
        r[3:0] = 4'd9;
        if (v[7:4] != 4'd0) begin
          r[7:4] = v[7:4] - 4'd1;
        end else begin
          r[7:4]  = 4'd9;
          r[11:8] = v[11:8] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign ptr_prev      = ptr_q - HIST_AW'(1);
  assign wr_r          = bus.write_i[RW-1:0];
  assign wr_c          = bus.write_j[RW-1:0];
  assign rt_r          = hist_i_q[ptr_prev][RW-1:0];
  assign rt_c          = hist_j_q[ptr_prev][RW-1:0];
  assign disp_r        = bus.display_i[RW-1:0];
  assign wr_in_range   = (32'(bus.write_i) < BOARD_N_U) && (32'(bus.write_j) < BOARD_N_U);
  assign disp_in_range = (32'(bus.display_i) < BOARD_N_U);
  // Only meaningful when wr_in_range; the AND keeps stray indices harmless.
  assign wr_occupied   = wr_in_range && (black_q[wr_r][wr_c] || white_q[wr_r][wr_c]);

  always_comb begin
    black_d       = black_q;
    white_d       = white_q;
    hist_i_d      = hist_i_q;
    hist_j_d      = hist_j_q;
    hist_c_d      = hist_c_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    bcd_d         = bcd_q;
    write_ack_d   = 1'b0;
    write_rej_d   = 1'b0;
    retract_ack_d = 1'b0;
    retract_nak_d = 1'b0;
    disp_black_d  = disp_in_range ? black_q[disp_r] : '0;
    disp_white_d  = disp_in_range ? white_q[disp_r] : '0;

    if (bus.clr) begin
      // History entries are left as-is: hist_cnt = 0 already hides them.
      for (int r = 0; r < BOARD_N; r++) begin
        black_d[r] = '0;
        white_d[r] = '0;
      end
      ptr_d        = '0;
      cnt_d        = '0;
      bcd_d        = '0;
      disp_black_d = '0;
      disp_white_d = '0;
    end else if (bus.retract) begin
      if (cnt_q == '0) begin
        retract_nak_d = 1'b1;
      end else begin
        ptr_d              = ptr_prev;
        black_d[rt_r][rt_c] = 1'b0;
        white_d[rt_r][rt_c] = 1'b0;
        cnt_d              = cnt_q - (HIST_AW + 1)'(1);
        bcd_d              = bcd_dec(bcd_q);
        retract_ack_d      = 1'b1;
      end
    end else if (bus.write) begin
      if (!wr_in_range || wr_occupied) begin
        write_rej_d = 1'b1;
      end else begin
        if (bus.write_color) white_d[wr_r][wr_c] = 1'b1;
        else                 black_d[wr_r][wr_c] = 1'b1;
        // A full ring overwrites the oldest entry; that stone stays placed.
        hist_i_d[ptr_q] = bus.write_i;
        hist_j_d[ptr_q] = bus.write_j;
        hist_c_d[ptr_q] = bus.write_color;
        ptr_d           = ptr_q + HIST_AW'(1);
        if (cnt_q != HIST_FULL) cnt_d = cnt_q + (HIST_AW + 1)'(1);
        bcd_d           = bcd_inc(bcd_q);
        write_ack_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int r = 0; r < BOARD_N; r++) begin
        black_q[r] <= '0;
        white_q[r] <= '0;
      end
      for (int h = 0; h < HIST_DEPTH; h++) begin
        hist_i_q[h] <= '0;
        hist_j_q[h] <= '0;
        hist_c_q[h] <= 1'b0;
      end
      ptr_q         <= '0;
      cnt_q         <= '0;
      bcd_q         <= '0;
      write_ack_q   <= 1'b0;
      write_rej_q   <= 1'b0;
      retract_ack_q <= 1'b0;
      retract_nak_q <= 1'b0;
      disp_black_q  <= '0;
      disp_white_q  <= '0;
    end else begin
      black_q       <= black_d;
      white_q       <= white_d;
      hist_i_q      <= hist_i_d;
      hist_j_q      <= hist_j_d;
      hist_c_q      <= hist_c_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      bcd_q         <= bcd_d;
      write_ack_q   <= write_ack_d;
      write_rej_q   <= write_rej_d;
      retract_ack_q <= retract_ack_d;
      retract_nak_q <= retract_nak_d;
      disp_black_q  <= disp_black_d;
      disp_white_q  <= disp_white_d;
    end
  end

  assign bus.display_black  = disp_black_q;
  assign bus.display_white  = disp_white_q;
  assign bus.write_ack      = write_ack_q;
  assign bus.write_rej      = write_rej_q;
  assign bus.retract_ack    = retract_ack_q;
  assign bus.retract_nak    = retract_nak_q;
  assign bus.last_valid     = (cnt_q != '0);
  assign bus.last_i         = (cnt_q != '0) ? hist_i_q[ptr_prev] : '0;
  assign bus.last_j         = (cnt_q != '0) ? hist_j_q[ptr_prev] : '0;
  assign bus.last_color     = (cnt_q != '0) ? hist_c_q[ptr_prev] : 1'b0;
  assign bus.hist_cnt       = cnt_q;
  assign bus.round_cnt_unit = bcd_q[3:0];
  assign bus.round_cnt_tens = bcd_q[7:4];
  assign bus.round_cnt_hund = bcd_q[11:8];

endmodule

// File: tb/tb_gobang_board_hist.sv
// tb/tb_gobang_board_hist.sv - directed self-checking bench for gobang_board_hist
module tb_gobang_board_hist;

  logic clk;
  logic rst_p;
  int   tests_run;
  int   tests_failed;
  int   acks;

  gobang_board_hist_if #(.BOARD_N(15), .IDX_W(5), .HIST_AW(4)) bus();

  gobang_board_hist #(
    .BOARD_N(15), .IDX_W(5), .HIST_DEPTH(16), .HIST_AW(4)
  ) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr         = 1'b0;
    bus.write       = 1'b0;
    bus.retract     = 1'b0;
    bus.write_i     = '0;
    bus.write_j     = '0;
    bus.write_color = 1'b0;
  endtask

  task automatic wr(input int i, input int j, input logic c);
    bus.write_i     = 5'(i);
    bus.write_j     = 5'(j);
    bus.write_color = c;
    bus.write       = 1'b1;
    step();
    bus.write       = 1'b0;
  endtask

  task automatic rt();
    bus.retract = 1'b1;
    step();
    bus.retract = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  task automatic read_row(input int r);
    bus.display_i = 5'(r);
    step();
  endtask

  function automatic logic [11:0] bcd();
    return {bus.round_cnt_hund, bus.round_cnt_tens, bus.round_cnt_unit};
  endfunction

  function automatic logic [3:0] pulses();
    return {bus.write_ack, bus.write_rej, bus.retract_ack, bus.retract_nak};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle();
    bus.display_i = '0;
    rst_p = 1'b1;
    repeat (2) step();

    // reset state
    check("rst_pulses", 32'(pulses()), 0);
    check("rst_hist",   32'(bus.hist_cnt), 0);
    check("rst_bcd",    32'(bcd()), 0);
    check("rst_lastv",  32'(bus.last_valid), 0);
    check("rst_disp",   32'(bus.display_black | bus.display_white), 0);
    rst_p = 1'b0;
    step();

    // first write
    wr(3, 4, 1'b0);
    check("w1_pulses", 32'(pulses()), 32'b1000);
    read_row(3);
    check("w1_pulse_gone", 32'(pulses()), 0);
    check("w1_black", 32'(bus.display_black), 32'h0010);
    check("w1_white", 32'(bus.display_white), 0);
    check("w1_bcd",   32'(bcd()), 12'h001);
    check("w1_hist",  32'(bus.hist_cnt), 1);
    check("w1_last",  32'({bus.last_valid, bus.last_i, bus.last_j, bus.last_color}),
          32'({1'b1, 5'd3, 5'd4, 1'b0}));

    // rejected writes
    wr(3, 4, 1'b1);
    check("rej_occ", 32'(pulses()), 32'b0100);
    wr(15, 0, 1'b0);
    check("rej_row", 32'(pulses()), 32'b0100);
    wr(0, 15, 1'b0);
    check("rej_col", 32'(pulses()), 32'b0100);
    read_row(3);
    check("rej_white", 32'(bus.display_white), 0);
    check("rej_black", 32'(bus.display_black), 32'h0010);
    check("rej_hist",  32'(bus.hist_cnt), 1);
    check("rej_bcd",   32'(bcd()), 12'h001);
    read_row(15);
    check("disp_oor", 32'(bus.display_black | bus.display_white), 0);

    // clear
    do_clr();
    check("clr_pulses", 32'(pulses()), 0);
    check("clr_hist",   32'(bus.hist_cnt), 0);
    check("clr_bcd",    32'(bcd()), 0);
    read_row(3);
    check("clr_row3", 32'(bus.display_black), 0);

    // three moves, four retracts
    wr(0, 0, 1'b0);
    wr(1, 1, 1'b1);
    wr(2, 2, 1'b0);
    rt();
    check("rt1_ack",  32'(pulses()), 32'b0010);
    check("rt1_last", 32'({bus.last_i, bus.last_j, bus.last_color}), 32'({5'd1, 5'd1, 1'b1}));
    read_row(2);
    check("rt1_row2", 32'(bus.display_black), 0);
    rt();
    check("rt2_ack", 32'(pulses()), 32'b0010);
    read_row(1);
    check("rt2_row1", 32'(bus.display_white), 0);
    rt();
    check("rt3_ack", 32'(pulses()), 32'b0010);
    rt();
    check("rt4_nak", 32'(pulses()), 32'b0001);
    check("rt_bcd",  32'(bcd()), 0);
    check("rt_lastv", 32'(bus.last_valid), 0);
    check("rt_lasti", 32'({bus.last_i, bus.last_j}), 0);

    // history wrap: 18 writes, 17 retracts
    do_clr();
    for (int k = 0; k < 18; k++) wr(k / 15, k % 15, 1'(k % 2));
    check("wrap_hist", 32'(bus.hist_cnt), 16);
    check("wrap_bcd",  32'(bcd()), 12'h018);
    acks = 0;
    for (int k = 0; k < 17; k++) begin
      rt();
      if (bus.retract_ack) acks++;
      if (k == 16) check("wrap_last_nak", 32'(pulses()), 32'b0001);
    end
    check("wrap_acks", 32'(acks), 16);
    check("wrap_bcd2", 32'(bcd()), 12'h002);
    check("wrap_hist2", 32'(bus.hist_cnt), 0);
    read_row(0);
    check("wrap_row0_b", 32'(bus.display_black), 32'h0001);
    check("wrap_row0_w", 32'(bus.display_white), 32'h0002);
    read_row(1);
    check("wrap_row1", 32'(bus.display_black | bus.display_white), 0);

    // same-cycle priority
    do_clr();
    wr(0, 0, 1'b0);
    wr(0, 1, 1'b1);
    bus.write_i = 5'd5; bus.write_j = 5'd5; bus.write_color = 1'b0;
    bus.write = 1'b1; bus.retract = 1'b1;
    step();
    idle();
    check("prio_rt_pulses", 32'(pulses()), 32'b0010);
    check("prio_rt_hist",   32'(bus.hist_cnt), 1);
    read_row(5);
    check("prio_row5", 32'(bus.display_black), 0);
    read_row(0);
    check("prio_row0", 32'({bus.display_black, bus.display_white}), 32'({15'h0001, 15'h0000}));
    bus.write_i = 5'd6; bus.write_j = 5'd6;
    bus.write = 1'b1; bus.clr = 1'b1;
    step();
    idle();
    check("prio_clr_pulses", 32'(pulses()), 0);
    check("prio_clr_hist",   32'(bus.hist_cnt), 0);
    read_row(6);
    check("prio_clr_row6", 32'(bus.display_black | bus.display_white), 0);

    // BCD carry/borrow
    do_clr();
    for (int k = 0; k < 99; k++) wr(k / 15, k % 15, 1'(k % 2));
    check("bcd_099",  32'(bcd()), 12'h099);
    check("bcd_hist", 32'(bus.hist_cnt), 16);
    wr(99 / 15, 99 % 15, 1'b1);
    check("bcd_100", 32'(bcd()), 12'h100);
    rt();
    check("bcd_back_099", 32'(bcd()), 12'h099);

    // asynchronous reset mid-operation
    bus.display_i = 5'd0;
    wr(6, 10, 1'b0);
    check("pre_rst_ack",   32'(pulses()), 32'b1000);
    check("pre_rst_black", 32'(bus.display_black), 32'h5555);
    check("pre_rst_white", 32'(bus.display_white), 32'h2AAA);
    #2;
    rst_p = 1'b1;
    #1;
    check("arst_pulses", 32'(pulses()), 0);
    check("arst_disp",   32'(bus.display_black | bus.display_white), 0);
    check("arst_bcd",    32'(bcd()), 0);
    check("arst_hist",   32'(bus.hist_cnt), 0);
    check("arst_lastv",  32'(bus.last_valid), 0);
    step();
    rst_p = 1'b0;
    read_row(0);
    check("post_rst_row0", 32'(bus.display_black | bus.display_white), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gobang_board_hist.md
Name: gobang_board_hist

Overview:
Parametrised successor to the fixed 15x15 board store and round counter behind the display wrapper. Holds a BOARD_N x BOARD_N board as black and white bit-planes and validates every write. Keeps a ring-buffer move history so several moves can be retracted in turn. Serves registered row reads to the VGA renderer and a BCD move count.

Parameters:
BOARD_N, 15, board edge length (5..31)
IDX_W, 5, width of row/column indices (must satisfy 2^IDX_W >= BOARD_N)
HIST_DEPTH, 16, number of retractable moves held in the history ring (power of two, >=2)
HIST_AW, 4, log2(HIST_DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst_p  in  1  asynchronous active-high reset
clr  in  1  synchronous board/history/count clear
write  in  1  one-cycle place-stone request
write_i  in  IDX_W  row to write
write_j  in  IDX_W  column to write
write_color  in  1  0 black, 1 white
retract  in  1  one-cycle undo request
display_i  in  IDX_W  row requested by renderer
display_black  out  BOARD_N  black stones of row display_i, bit j = column j
display_white  out  BOARD_N  white stones of row display_i
write_ack  out  1  pulse: write accepted
write_rej  out  1  pulse: write refused (occupied or out of range)
retract_ack  out  1  pulse: move removed
retract_nak  out  1  pulse: retract refused (history empty)
last_valid  out  1  history non-empty
last_i, last_j  out  IDX_W each  position of most recent retractable move
last_color  out  1  colour of that move
hist_cnt  out  HIST_AW+1  retractable moves held (0..HIST_DEPTH)
round_cnt_unit, round_cnt_tens, round_cnt_hund  out  4 each  BCD count of stones on board

Behaviour:
- Reset (rst_p=1, async): board empty; history empty, ptr=0. display_black/white=0. All pulses 0. last_* = 0. hist_cnt=0. BCD count 000.
- Priority in one cycle: clr > retract > write. A lower-priority request in the same cycle is dropped, with no ack or rej pulse.
- clr: same end state as reset, applied on the next edge. Does not pulse ack/rej/nak.
- write:
  - Rejected if write_i>=BOARD_N, write_j>=BOARD_N, or the cell holds either colour. write_rej=1 next cycle; no state change.
  - Otherwise the colour bit is set, the entry {i,j,color} is pushed at ptr, ptr=ptr+1 mod HIST_DEPTH, and write_ack=1 next cycle.
  - hist_cnt increments, saturating at HIST_DEPTH. When full, the push overwrites the oldest entry; that stone stays on the board but can no longer be retracted.
  - BCD count +1, with decimal carry unit->tens->hund, saturating at 999.
- retract:
  - If hist_cnt=0: retract_nak=1 next cycle; nothing changes.
  - Otherwise ptr=ptr-1 mod HIST_DEPTH and the cell at entry[ptr] is cleared in both planes. hist_cnt-1, BCD count -1 with borrow (never below 000), retract_ack=1 next cycle.
- Write and retract on consecutive cycles are both honoured. Board updates are visible to the next request with no hazard.
- All ack/rej/nak outputs are single-cycle registered pulses. They are mutually exclusive in any cycle.
- last_*: combinational from entry[ptr-1] when hist_cnt>0, else 0. They reflect state after each edge.
- Display read: display_black/white are registered, one-cycle latency from display_i. If display_i>=BOARD_N, the next cycle outputs 0. A write or retract to row r on edge k shows on a read of r sampled at edge k+1.
- Board storage is flip-flop or distributed; no block RAM latency assumptions.
- Reset asserted mid-operation aborts any pending pulse; outputs return to reset values asynchronously.

Test Plan:
- Reset, then write (3,4,black) -> write_ack next cycle; display_i=3 gives display_black=15'h0010 one cycle later; count 001, hist_cnt=1, last=(3,4,0).
- Write (3,4,white) onto the occupied cell, then (15,0) with BOARD_N=15 -> write_rej twice; board, hist_cnt and count unchanged.
- Write 3 moves, retract 4 times -> three retract_ack pulses clearing the cells in reverse order, then retract_nak; count 000, last_valid=0.
- HIST_DEPTH=16: write 18 distinct moves, retract 17 times -> 16 ack then nak; first 2 stones remain; count 002.
- Same cycle write=1, retract=1 with hist_cnt=2 -> only retract_ack; the write cell stays empty. Same cycle clr=1, write=1 -> board empty, no pulse.
- 99 writes on BOARD_N=15 -> BCD 0,9,9; one more -> 1,0,0; one retract -> 0,9,9. Assert rst_p mid-sequence -> all outputs 0 immediately.
